fetch_line_buf: RTL and testbench

Two-bank instruction byte buffer between the I-cache fill path and the decoder. It accepts 16-byte cache lines into alternating banks and presents a 16-byte window starting at the current decode byte. It retires the byte count the decoder consumes each cycle, and frees a bank as soon as the read point leaves it. It reports bank occupancy to the fetch control FSM, which decides when to load each bank.

---
 rtl/fetch_line_buf.sv | 111 +++++++++++
 tb/tb_fetch_line_buf.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_line_buf.sv
// Two-bank 16 B instruction byte buffer feeding the decoder window.
// Define FETCH_BUF_ZERO_MASK_EN to zero bytes past fb_avail and reset storage.
module fetch_line_buf (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ic_valid,
    input  logic [127:0] ic_data,
    input  logic         flush,
    input  logic [3:0]   flush_off,
    input  logic         de_take,
    input  logic [4:0]   de_len,
    output logic [127:0] fb_bytes,
    output logic [4:0]   fb_avail,
    output logic [1:0]   fb_free,
    output logic         fb_fill_rdy
);

    logic [1:0] bank_v;
    logic [4:0] rd_ptr;
    logic       wr_bank;
    logic [7:0] mem [32];

    logic [5:0] avail_full;
    logic       take_ok;
    logic       fill_ok;
    logic [4:0] new_ptr;
    logic       free_bank;
    logic [1:0] bank_set;
    logic [1:0] bank_clr;

    assign fb_free     = ~bank_v;
    assign fb_fill_rdy = ~bank_v[wr_bank];

    always_comb begin
        avail_full = '0;
        if (bank_v[rd_ptr[4]]) begin
            avail_full = 6'd16 - {2'b00, rd_ptr[3:0]};
            if (bank_v[~rd_ptr[4]]) begin
                avail_full = avail_full + 6'd16;
            end
        end
    end

    // A full 32 B window does not fit the 5-bit port; report 31 so the
    // decoder still sees more than a full instruction available.
    assign fb_avail = avail_full[5] ? 5'd31 : avail_full[4:0];

    assign take_ok   = de_take && (de_len != 5'd0)
                       && ({1'b0, de_len} <= avail_full);
    assign fill_ok   = ic_valid && fb_fill_rdy;
    assign new_ptr   = rd_ptr + de_len;
    assign free_bank = take_ok && (new_ptr[4] != rd_ptr[4]);
    assign bank_set  = fill_ok ? (2'b01 << wr_bank) : 2'b00;
    assign bank_clr  = free_bank ? (2'b01 << rd_ptr[4]) : 2'b00;

    always_comb begin
        fb_bytes = '0;
        for (int k = 0; k < 16; k++) begin
`ifdef FETCH_BUF_ZERO_MASK_EN
            if (6'(k) < avail_full) begin
                fb_bytes[8*k +: 8] = mem[rd_ptr + 5'(k)];
            end
`else
            fb_bytes[8*k +: 8] = mem[rd_ptr + 5'(k)];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_v  <= 2'b00;
            rd_ptr  <= 5'd0;
            wr_bank <= 1'b0;
        end else if (flush) begin
            bank_v  <= 2'b00;
            rd_ptr  <= {1'b0, flush_off};
            wr_bank <= 1'b0;
        end else begin
            bank_v <= (bank_v | bank_set) & ~bank_clr;
            if (fill_ok) begin
                wr_bank <= ~wr_bank;
            end
            if (take_ok) begin
                rd_ptr <= new_ptr;
            end
        end
    end

`ifdef FETCH_BUF_ZERO_MASK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (fill_ok && !flush) begin
            for (int i = 0; i < 16; i++) begin
                mem[{wr_bank, 4'(i)}] <= ic_data[8*i +: 8];
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst_n && fill_ok && !flush) begin
            for (int i = 0; i < 16; i++) begin
                mem[{wr_bank, 4'(i)}] <= ic_data[8*i +: 8];
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_line_buf.sv
// Directed bench for fetch_line_buf: fills, takes, wrap, flush, masking.
module tb_fetch_line_buf;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ic_valid;
    logic [127:0] ic_data;
    logic         flush;
    logic [3:0]   flush_off;
    logic         de_take;
    logic [4:0]   de_len;
    logic [127:0] fb_bytes;
    logic [4:0]   fb_avail;
    logic [1:0]   fb_free;
    logic         fb_fill_rdy;

    int pass_cnt = 0;
    int total_cnt = 0;

    fetch_line_buf dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ic_valid   (ic_valid),
        .ic_data    (ic_data),
        .flush      (flush),
        .flush_off  (flush_off),
        .de_take    (de_take),
        .de_len     (de_len),
        .fb_bytes   (fb_bytes),
        .fb_avail   (fb_avail),
        .fb_free    (fb_free),
        .fb_fill_rdy(fb_fill_rdy)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] mk_line(input logic [7:0] base);
        logic [127:0] l;
        for (int i = 0; i < 16; i++) l[8*i +: 8] = base + 8'(i);
        return l;
    endfunction

    task automatic idle();
        ic_valid = 1'b0; flush = 1'b0; de_take = 1'b0;
        de_len = 5'd0; flush_off = 4'd0;
    endtask

    // Inputs applied now take effect at the next edge; sample 1 after it.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic fill(input logic [7:0] base);
        ic_valid = 1'b1; ic_data = mk_line(base);
        step();
    endtask

    task automatic take(input logic [4:0] len);
        de_take = 1'b1; de_len = len;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; step(); step(); rst_n = 1'b1;
        total_cnt++;
        if (fb_avail !== 5'd0) $display("FAIL reset_avail got %0d want 0", fb_avail);
        else pass_cnt++;
        total_cnt++;
        if (fb_free !== 2'b11) $display("FAIL reset_free got %b want 11", fb_free);
        else pass_cnt++;
        total_cnt++;
        if (fb_fill_rdy !== 1'b1) $display("FAIL reset_rdy got %b want 1", fb_fill_rdy);
        else pass_cnt++;
    endtask

    task automatic test_fill_one();
        fill(8'h00);
        total_cnt++;
        if (fb_avail !== 5'd16) $display("FAIL fill1_avail got %0d want 16", fb_avail);
        else pass_cnt++;
        total_cnt++;
        if (fb_bytes[7:0] !== 8'h00) $display("FAIL fill1_b0 got %h want 00", fb_bytes[7:0]);
        else pass_cnt++;
        total_cnt++;
        if (fb_bytes !== mk_line(8'h00)) $display("FAIL fill1_win got %h want %h", fb_bytes, mk_line(8'h00));
        else pass_cnt++;
        total_cnt++;
        if (fb_free !== 2'b10) $display("FAIL fill1_free got %b want 10", fb_free);
        else pass_cnt++;
        total_cnt++;
        if (fb_fill_rdy !== 1'b1) $display("FAIL fill1_rdy got %b want 1", fb_fill_rdy);
        else pass_cnt++;
    endtask

    task automatic test_full_drop();
        fill(8'h10);
        total_cnt++;
        if (fb_free !== 2'b00) $display("FAIL full_free got %b want 00", fb_free);
        else pass_cnt++;
        total_cnt++;
        if (fb_fill_rdy !== 1'b0) $display("FAIL full_rdy got %b want 0", fb_fill_rdy);
        else pass_cnt++;
        fill(8'h20);
        total_cnt++;
        if (fb_bytes[7:0] !== 8'h00) $display("FAIL drop_b0 got %h want 00", fb_bytes[7:0]);
        else pass_cnt++;
        take(5'd16);
        total_cnt++;
        if (fb_avail !== 5'd16) $display("FAIL t16_avail got %0d want 16", fb_avail);
        else pass_cnt++;
        total_cnt++;
        if (fb_free !== 2'b01) $display("FAIL t16_free got %b want 01", fb_free);
        else pass_cnt++;
        total_cnt++;
        if (fb_fill_rdy !== 1'b1) $display("FAIL t16_rdy got %b want 1", fb_fill_rdy);
        else pass_cnt++;
        total_cnt++;
        if (fb_bytes[7:0] !== 8'h10) $display("FAIL t16_b0 got %h want 10", fb_bytes[7:0]);
        else pass_cnt++;
    endtask

    task automatic test_cross();
        rst_n = 1'b0; step(); rst_n = 1'b1;
        fill(8'h00);
        fill(8'h10);
        take(5'd12);
        total_cnt++;
        if (fb_avail !== 5'd20) $display("FAIL x12_avail got %0d want 20", fb_avail);
        else pass_cnt++;
        total_cnt++;
        if (fb_free !== 2'b00) $display("FAIL x12_free got %b want 00", fb_free);
        else pass_cnt++;
        take(5'd6);
        total_cnt++;
        if (fb_avail !== 5'd14) $display("FAIL x6_avail got %0d want 14", fb_avail);
        else pass_cnt++;
        total_cnt++;
        if (fb_free !== 2'b01) $display("FAIL x6_free got %b want 01", fb_free);
        else pass_cnt++;
        total_cnt++;
        if (fb_bytes[7:0] !== 8'h12) $display("FAIL x6_b0 got %h want 12", fb_bytes[7:0]);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        take(5'd10);
        total_cnt++;
        if (fb_avail !== 5'd4) $display("FAIL w28_avail got %0d want 4", fb_avail);
        else pass_cnt++;
        take(5'd5);
        total_cnt++;
        if (fb_avail !== 5'd4) $display("FAIL over_avail got %0d want 4", fb_avail);
        else pass_cnt++;
        total_cnt++;
        if (fb_bytes[7:0] !== 8'h1C) $display("FAIL over_b0 got %h want 1c", fb_bytes[7:0]);
        else pass_cnt++;
        take(5'd0);
        total_cnt++;
        if (fb_bytes[7:0] !== 8'h1C) $display("FAIL zero_len_b0 got %h want 1c", fb_bytes[7:0]);
        else pass_cnt++;
        fill(8'h40);
        total_cnt++;
        if (fb_avail !== 5'd20) $display("FAIL wfill_avail got %0d want 20", fb_avail);
        else pass_cnt++;
        take(5'd5);
        total_cnt++;
        if (fb_avail !== 5'd15) $display("FAIL wrap_avail got %0d want 15", fb_avail);
        else pass_cnt++;
        total_cnt++;
        if (fb_free !== 2'b10) $display("FAIL wrap_free got %b want 10", fb_free);
        else pass_cnt++;
        total_cnt++;
        if (fb_bytes[7:0] !== 8'h41) $display("FAIL wrap_b0 got %h want 41", fb_bytes[7:0]);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        ic_valid = 1'b1; ic_data = mk_line(8'h50);
        de_take = 1'b1; de_len = 5'd15;
        step();
        total_cnt++;
        if (fb_avail !== 5'd16) $display("FAIL b2b1_avail got %0d want 16", fb_avail);
        else pass_cnt++;
        total_cnt++;
        if (fb_free !== 2'b01) $display("FAIL b2b1_free got %b want 01", fb_free);
        else pass_cnt++;
        total_cnt++;
        if (fb_bytes[7:0] !== 8'h50) $display("FAIL b2b1_b0 got %h want 50", fb_bytes[7:0]);
        else pass_cnt++;
        ic_valid = 1'b1; ic_data = mk_line(8'h60);
        de_take = 1'b1; de_len = 5'd16;
        step();
        total_cnt++;
        if (fb_avail !== 5'd16) $display("FAIL b2b2_avail got %0d want 16", fb_avail);
        else pass_cnt++;
        total_cnt++;
        if (fb_free !== 2'b10) $display("FAIL b2b2_free got %b want 10", fb_free);
        else pass_cnt++;
        total_cnt++;
        if (fb_bytes[7:0] !== 8'h60) $display("FAIL b2b2_b0 got %h want 60", fb_bytes[7:0]);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        // Bank 1 still holds line 0x50 for the stale-byte check later.
        flush = 1'b1; flush_off = 4'd9;
        ic_valid = 1'b1; ic_data = mk_line(8'h70);
        de_take = 1'b1; de_len = 5'd4;
        step();
        total_cnt++;
        if (fb_avail !== 5'd0) $display("FAIL fl_avail got %0d want 0", fb_avail);
        else pass_cnt++;
        total_cnt++;
        if (fb_free !== 2'b11) $display("FAIL fl_free got %b want 11", fb_free);
        else pass_cnt++;
        total_cnt++;
        if (fb_fill_rdy !== 1'b1) $display("FAIL fl_rdy got %b want 1", fb_fill_rdy);
        else pass_cnt++;
        fill(8'h80);
        total_cnt++;
        if (fb_avail !== 5'd7) $display("FAIL flf_avail got %0d want 7", fb_avail);
        else pass_cnt++;
        total_cnt++;
        if (fb_bytes[7:0] !== 8'h89) $display("FAIL flf_b0 got %h want 89", fb_bytes[7:0]);
        else pass_cnt++;
        total_cnt++;
        if (fb_free !== 2'b10) $display("FAIL flf_free got %b want 10", fb_free);
        else pass_cnt++;
    endtask

    task automatic test_mask();
        logic [127:0] exp;
        take(5'd4);
        total_cnt++;
        if (fb_avail !== 5'd3) $display("FAIL m_avail got %0d want 3", fb_avail);
        else pass_cnt++;
        total_cnt++;
        if (fb_bytes[23:0] !== 24'h8F8E8D) $display("FAIL m_low got %h want 8f8e8d", fb_bytes[23:0]);
        else pass_cnt++;
        exp = '0;
`ifndef FETCH_BUF_ZERO_MASK_EN
        for (int k = 3; k < 16; k++) exp[8*k +: 8] = 8'h50 + 8'(k - 3);
`endif
        total_cnt++;
        if (fb_bytes[127:24] !== exp[127:24]) $display("FAIL m_high got %h want %h", fb_bytes[127:24], exp[127:24]);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0; step(); rst_n = 1'b1;
        total_cnt++;
        if (fb_avail !== 5'd0) $display("FAIL rm_avail got %0d want 0", fb_avail);
        else pass_cnt++;
        total_cnt++;
        if (fb_free !== 2'b11) $display("FAIL rm_free got %b want 11", fb_free);
        else pass_cnt++;
        fill(8'h90);
        total_cnt++;
        if (fb_avail !== 5'd16) $display("FAIL rmf_avail got %0d want 16", fb_avail);
        else pass_cnt++;
        total_cnt++;
        if (fb_bytes[7:0] !== 8'h90) $display("FAIL rmf_b0 got %h want 90", fb_bytes[7:0]);
        else pass_cnt++;
    endtask

    initial begin
        rst_n = 1'b0;
        ic_data = '0;
        idle();
        test_reset();
        test_fill_one();
        test_full_drop();
        test_cross();
        test_wrap();
        test_back_to_back();
        test_flush();
        test_mask();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
